pfsm_rule_engine: RTL and testbench



---
 rtl/pfsm_rule_engine.sv | 144 ++++++++++++++
 tb/tb_pfsm_rule_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pfsm_rule_engine.sv
// pfsm_rule_engine: programmable Mealy-style controller driven by a loadable priority rule table.
// All flops update on the falling edge of CK.
// RST is an asynchronous, active-high reset. It clears STATE, OUT, MATCH and every rule valid bit.
//
// Ports:
//   CK, RST          clock (falling edge) and asynchronous active-high reset
//   CLR              synchronous clear of STATE/OUT/MATCH
//   EN               evaluate the rule table this edge (0 = hold)
//   IN               primary inputs
//   OUT/STATE/MATCH  registered outputs; MATCH = a rule fired on the last evaluating edge
//   CFG_*            rule write port; CFG_WE writes entry CFG_ADDR
//   SE/SI/SO         scan enable, scan in and scan out (present only with PFSM_SCAN_EN)
//
// Optional feature macro: PFSM_SCAN_EN.
// It adds a scan chain SI -> STATE[0..] -> OUT[0..] -> MATCH -> SO.
module pfsm_rule_engine #(
  parameter int unsigned IN_W      = 18,
  parameter int unsigned OUT_W     = 19,
  parameter int unsigned STATE_W   = 5,
  parameter int unsigned NUM_RULES = 32,
  parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
`ifdef PFSM_SCAN_EN
  input  logic                         SE,
  input  logic                         SI,
  output logic                         SO,
`endif
  input  logic                         CK,
  input  logic                         RST,
  input  logic                         CLR,
  input  logic                         EN,
  input  logic [IN_W-1:0]              IN,
  output logic [OUT_W-1:0]             OUT,
  output logic [STATE_W-1:0]           STATE,
  output logic                         MATCH,
  input  logic                         CFG_WE,
  input  logic [$clog2(NUM_RULES)-1:0] CFG_ADDR,
  input  logic                         CFG_VLD,
  input  logic [STATE_W-1:0]           CFG_CUR,
  input  logic [IN_W-1:0]              CFG_MASK,
  input  logic [IN_W-1:0]              CFG_VAL,
  input  logic [STATE_W-1:0]           CFG_NXT,
  input  logic [OUT_W-1:0]             CFG_OUT
);

  // Rule table: only the valid bits are reset; the payload is don't-care while invalid.
  logic [NUM_RULES-1:0] r_vld;
  logic [STATE_W-1:0]   r_cur      [NUM_RULES];
  logic [IN_W-1:0]      r_mask     [NUM_RULES];
  logic [IN_W-1:0]      r_val      [NUM_RULES];
  logic [STATE_W-1:0]   r_nxt      [NUM_RULES];
  logic [OUT_W-1:0]     r_rule_out [NUM_RULES];

  logic [STATE_W-1:0] r_state;
  logic [OUT_W-1:0]   r_out;
  logic               r_match;

  logic               w_hit;
  logic [STATE_W-1:0] w_win_nxt;
  logic [OUT_W-1:0]   w_win_out;
  logic [STATE_W-1:0] w_state_d;
  logic [OUT_W-1:0]   w_out_d;
  logic               w_match_d;

  // Priority search: the first (lowest-index) matching rule wins.
  // Later hits are ignored once w_hit is set.
  always_comb begin
    w_hit     = 1'b0;
    w_win_nxt = '0;
    w_win_out = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (!w_hit && r_vld[i] && (r_cur[i] == r_state) &&
          (((IN ^ r_val[i]) & r_mask[i]) == '0)) begin
        w_hit     = 1'b1;
        w_win_nxt = r_nxt[i];
        w_win_out = r_rule_out[i];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_out_d   = r_out;
    w_match_d = r_match;
    if (CLR) begin
      w_state_d = RESET_STATE;
      w_out_d   = '0;
      w_match_d = 1'b0;
    end else if (EN) begin
      if (w_hit) begin
        w_state_d = w_win_nxt;
        w_out_d   = w_win_out;
        w_match_d = 1'b1;
      end else begin
        w_out_d   = '0;
        w_match_d = 1'b0;
      end
    end
`ifdef PFSM_SCAN_EN
    // Scan shift takes over the state/output flops; the table keeps accepting writes.
    if (SE) begin
      w_state_d = {r_state[STATE_W-2:0], SI};
      w_out_d   = {r_out[OUT_W-2:0], r_state[STATE_W-1]};
      w_match_d = r_out[OUT_W-1];
    end
`endif
  end

  always_ff @(negedge CK or posedge RST) begin
    if (RST) begin
      r_state <= RESET_STATE;
      r_out   <= '0;
      r_match <= 1'b0;
      r_vld   <= '0;
    end else begin
      r_state <= w_state_d;
      r_out   <= w_out_d;
      r_match <= w_match_d;
      if (CFG_WE) begin
        r_vld[CFG_ADDR] <= CFG_VLD;
      end
    end
  end

  // Payload writes need no reset.
  // Evaluation this edge reads the old contents, since the writes land on the same edge.
  always_ff @(negedge CK) begin
    if (CFG_WE) begin
      r_cur[CFG_ADDR]      <= CFG_CUR;
      r_mask[CFG_ADDR]     <= CFG_MASK;
      r_val[CFG_ADDR]      <= CFG_VAL;
      r_nxt[CFG_ADDR]      <= CFG_NXT;
      r_rule_out[CFG_ADDR] <= CFG_OUT;
    end
  end

  assign STATE = r_state;
  assign OUT   = r_out;
  assign MATCH = r_match;
`ifdef PFSM_SCAN_EN
  assign SO    = r_match;
`endif

endmodule

// File: tb/tb_pfsm_rule_engine.sv
// Directed bench for pfsm_rule_engine.
// The DUT updates on the falling edge of CK.
// The bench drives inputs and samples outputs on the rising edge.
module tb_pfsm_rule_engine;
  localparam int unsigned IN_W = 18, OUT_W = 19, STATE_W = 5, NUM_RULES = 32;

  logic                 CK, RST, CLR, EN;
  logic [IN_W-1:0]      IN;
  logic [OUT_W-1:0]     OUT;
  logic [STATE_W-1:0]   STATE;
  logic                 MATCH;
  logic                 CFG_WE, CFG_VLD;
  logic [4:0]           CFG_ADDR;
  logic [STATE_W-1:0]   CFG_CUR, CFG_NXT;
  logic [IN_W-1:0]      CFG_MASK, CFG_VAL;
  logic [OUT_W-1:0]     CFG_OUT;
`ifdef PFSM_SCAN_EN
  logic                 SE, SI, SO;
  logic [24:0]          scan_img;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  pfsm_rule_engine #(
    .IN_W(IN_W), .OUT_W(OUT_W), .STATE_W(STATE_W), .NUM_RULES(NUM_RULES), .RESET_STATE('0)
  ) dut (
`ifdef PFSM_SCAN_EN
    .SE(SE), .SI(SI), .SO(SO),
`endif
    .CK(CK), .RST(RST), .CLR(CLR), .EN(EN), .IN(IN), .OUT(OUT), .STATE(STATE), .MATCH(MATCH),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_VLD(CFG_VLD), .CFG_CUR(CFG_CUR),
    .CFG_MASK(CFG_MASK), .CFG_VAL(CFG_VAL), .CFG_NXT(CFG_NXT), .CFG_OUT(CFG_OUT)
  );

  initial CK = 1'b1;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [4:0] st, input logic [18:0] o,
                      input logic m);
    chk({tag, ".STATE"}, 32'(STATE), 32'(st));
    chk({tag, ".OUT"}, 32'(OUT), 32'(o));
    chk({tag, ".MATCH"}, 32'(MATCH), 32'(m));
  endtask

  // One DUT edge; the config strobe is one-shot and dropped after the edge.
  task automatic step();
    @(negedge CK);
    @(posedge CK);
    CFG_WE = 1'b0;
  endtask

  task automatic cfg(input logic [4:0] a, input logic v, input logic [4:0] cur,
                     input logic [17:0] mask, input logic [17:0] val,
                     input logic [4:0] nxt, input logic [18:0] o);
    CFG_WE = 1'b1; CFG_ADDR = a; CFG_VLD = v; CFG_CUR = cur;
    CFG_MASK = mask; CFG_VAL = val; CFG_NXT = nxt; CFG_OUT = o;
  endtask

  initial begin
    RST = 1'b1; CLR = 1'b0; EN = 1'b0; IN = '0;
    CFG_WE = 1'b0; CFG_ADDR = '0; CFG_VLD = 1'b0; CFG_CUR = '0;
    CFG_MASK = '0; CFG_VAL = '0; CFG_NXT = '0; CFG_OUT = '0;
`ifdef PFSM_SCAN_EN
    SE = 1'b0; SI = 1'b0;
`endif
    @(posedge CK);
    chk3("reset", 5'd0, 19'h0, 1'b0);
    RST = 1'b0;

    // Empty table: nothing ever matches.
    EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN = 18'(i * 37 + 5);
      step();
      chk3("empty", 5'd0, 19'h0, 1'b0);
    end

    // Single rule, then no rule for the destination state.
    EN = 1'b0;
    cfg(5'd3, 1'b1, 5'd0, 18'h1, 18'h1, 5'd5, 19'hAA);
    step();
    chk3("cfg_hold", 5'd0, 19'h0, 1'b0);
    EN = 1'b1; IN = 18'h1;
    step();
    chk3("rule3", 5'd5, 19'hAA, 1'b1);
    step();
    chk3("s5_nomatch", 5'd5, 19'h0, 1'b0);

    // Priority between rules 2 and 7.
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk3("clr", 5'd0, 19'h0, 1'b0);
    EN = 1'b0;
    cfg(5'd2, 1'b1, 5'd0, 18'h2, 18'h2, 5'd9, 19'h11);
    step();
    cfg(5'd7, 1'b1, 5'd0, 18'h4, 18'h4, 5'd12, 19'h22);
    step();
    EN = 1'b1; IN = 18'h6;
    step();
    chk3("prio", 5'd9, 19'h11, 1'b1);
    // Invalidate rule 2 while CLR is active; the write must still land.
    cfg(5'd2, 1'b0, 5'd0, 18'h2, 18'h2, 5'd9, 19'h11);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk3("clr_cfg", 5'd0, 19'h0, 1'b0);
    step();
    chk3("rule7", 5'd12, 19'h22, 1'b1);

    // Read-before-write on the evaluating edge.
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk3("clr2", 5'd0, 19'h0, 1'b0);
    IN = 18'h8;
    cfg(5'd0, 1'b1, 5'd0, 18'h0, 18'h0, 5'd4, 19'h33);
    step();
    chk3("rbw", 5'd0, 19'h0, 1'b0);
    step();
    chk3("new_rule", 5'd4, 19'h33, 1'b1);

    // Hold with EN=0, and CLR beating a match.
    EN = 1'b0;
    cfg(5'd1, 1'b1, 5'd4, 18'h0, 18'h0, 5'd9, 19'h44);
    step();
    chk3("hold", 5'd4, 19'h33, 1'b1);
    EN = 1'b1;
    step();
    chk3("s9", 5'd9, 19'h44, 1'b1);
    EN = 1'b0;
    cfg(5'd4, 1'b1, 5'd9, 18'h0, 18'h0, 5'd1, 19'h55);
    step();
    chk3("hold_cfg", 5'd9, 19'h44, 1'b1);
    step();
    chk3("hold_match", 5'd9, 19'h44, 1'b1);
    EN = 1'b1; CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk3("clr_over", 5'd0, 19'h0, 1'b0);
    EN = 1'b0;
    step();
    chk3("hold0", 5'd0, 19'h0, 1'b0);

    // Asynchronous reset mid-cycle wipes state and table.
    EN = 1'b1;
    step();
    chk3("pre_rst", 5'd4, 19'h33, 1'b1);
    #2 RST = 1'b1;
    #1 chk3("async_rst", 5'd0, 19'h0, 1'b0);
    @(posedge CK);
    RST = 1'b0;
    step();
    chk3("post_rst", 5'd0, 19'h0, 1'b0);

`ifdef PFSM_SCAN_EN
    EN = 1'b0;
    cfg(5'd0, 1'b1, 5'd0, 18'h0, 18'h0, 5'h15, 19'h0);
    step();
    EN = 1'b1;
    step();
    chk3("scan_load", 5'h15, 19'h0, 1'b1);
    step();
    chk3("scan_idle", 5'h15, 19'h0, 1'b0);
    // Chain image in chain order: bit p is position p from SI.
    scan_img = {1'b0, 19'h0, 5'h15};
    EN = 1'b0; SE = 1'b1; SI = 1'b0;
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("scan_so%0d", k), 32'(SO), (k < 25) ? 32'(scan_img[24-k]) : 32'd0);
      step();
    end
    chk3("scan_empty", 5'd0, 19'h0, 1'b0);
    SE = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end
endmodule
